// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and the coefficient type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kyber_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int COEFF_W   = 12;
    localparam int BARRETT_K = 24;
    localparam int BARRETT_M = 5039;   // floor(2^24 / 3329)

    typedef logic [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/barrett_reduce.sv
// Barrett reduction of an unsigned 2*WIDTH-bit product to a residue in [0, Q-1].
// Latency: 1 cycle (residue registered alongside its valid bit).
// Backpressure: none; accepts one product per cycle.
module barrett_reduce
    import kyber_pkg::*;
#(
    parameter int Q         = KYBER_Q,
    parameter int WIDTH     = COEFF_W,
    parameter int BARRETT_K = kyber_pkg::BARRETT_K,
    parameter int BARRETT_M = kyber_pkg::BARRETT_M
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    input  logic [2*WIDTH-1:0] p,
    output logic               out_vld,
    output logic [WIDTH-1:0]   r
);

    localparam int PW = 2 * WIDTH;
    localparam int MW = $clog2(BARRETT_M + 1);
    localparam int XW = PW + MW;

    logic [XW-1:0]    x;
    logic [PW-1:0]    t;
    logic [PW-1:0]    r0;
    logic [PW-1:0]    r1;
    logic [WIDTH-1:0] r2;

    // Quotient estimate never exceeds floor(p/Q), so r0 is non-negative and
    // below 3Q; two conditional subtractions finish the reduction.
    always_comb begin
        x  = XW'(p) * XW'(BARRETT_M);
        t  = PW'(x >> BARRETT_K);
        r0 = p - t * PW'(Q);
        r1 = (r0 >= PW'(Q)) ? r0 - PW'(Q) : r0;
        r2 = WIDTH'((r1 >= PW'(Q)) ? r1 - PW'(Q) : r1);
    end

    // Register the residue; data only moves when a valid product arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            r       <= '0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                r <= r2;
            end
        end
    end

endmodule

// File: rtl/ntt_butterfly.sv
// Cooley-Tukey butterfly over Z_q: even = (a + b*w) mod Q, odd = (a - b*w) mod Q.
// Latency: 3 cycles (multiply / Barrett reduce / modular add-sub), one op per cycle.
// Backpressure: none; the consumer must accept every out_valid pulse.
module ntt_butterfly
    import kyber_pkg::*;
#(
    parameter int Q         = KYBER_Q,
    parameter int WIDTH     = COEFF_W,
    parameter int BARRETT_K = kyber_pkg::BARRETT_K,
    parameter int BARRETT_M = kyber_pkg::BARRETT_M
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] w,
    output logic             out_valid,
    output logic [WIDTH-1:0] even,
    output logic [WIDTH-1:0] odd
);

    logic                 s1_vld;
    logic [2*WIDTH-1:0]   s1_p;
    logic [WIDTH-1:0]     s1_a;
    logic                 s2_vld;
    logic [WIDTH-1:0]     s2_r;
    logic [WIDTH-1:0]     s2_a;
    logic [WIDTH-1:0]     a_norm;
    logic [WIDTH:0]       sum;
    logic signed [WIDTH:0] diff;
    logic [WIDTH-1:0]     even_nxt;
    logic [WIDTH-1:0]     odd_nxt;

    // a may be up to 4095 (< 2Q), so a single subtraction brings it into range.
    always_comb begin
        a_norm = (a >= WIDTH'(Q)) ? a - WIDTH'(Q) : a;
    end

    // Stage 1: full-width product and normalised a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_p   <= '0;
            s1_a   <= '0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_p <= (2*WIDTH)'(b) * (2*WIDTH)'(w);
                s1_a <= a_norm;
            end
        end
    end

    // Stage 2: product reduction; a' travels alongside to stay bound to its result.
    barrett_reduce #(
        .Q         (Q),
        .WIDTH     (WIDTH),
        .BARRETT_K (BARRETT_K),
        .BARRETT_M (BARRETT_M)
    ) u_barrett (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (s1_vld),
        .p       (s1_p),
        .out_vld (s2_vld),
        .r       (s2_r)
    );

    // Stage-2 carry of a' matching the Barrett register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_a <= '0;
        end else if (s1_vld) begin
            s2_a <= s1_a;
        end
    end

    // Modular add and subtract; both operands are already in [0, Q-1].
    always_comb begin
        sum      = {1'b0, s2_a} + {1'b0, s2_r};
        even_nxt = WIDTH'((sum >= (WIDTH+1)'(Q)) ? sum - (WIDTH+1)'(Q) : sum);
        diff     = $signed({1'b0, s2_a}) - $signed({1'b0, s2_r});
        odd_nxt  = (diff < 0) ? WIDTH'(diff + $signed((WIDTH+1)'(Q))) : WIDTH'(diff);
    end

    // Stage 3: output registers hold their last result across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            even      <= '0;
            odd       <= '0;
        end else begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                even <= even_nxt;
                odd  <= odd_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly against a plain modular-arithmetic model.
// Latency: every cycle compares the outputs with the op driven three edges earlier.
// Backpressure: none exercised; the design has no ready.
module tb_ntt_butterfly;
    import kyber_pkg::*;

    localparam int QM = KYBER_Q;

    typedef struct {
        bit vld;
        int ev;
        int od;
    } exp_t;

    logic   clk;
    logic   rst_n;
    logic   in_valid;
    coeff_t a;
    coeff_t b;
    coeff_t w;
    logic   out_valid;
    coeff_t even;
    coeff_t odd;

    int   errors = 0;
    int   checks = 0;
    exp_t expq[$];

    ntt_butterfly dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .w         (w),
        .out_valid (out_valid),
        .even      (even),
        .odd       (odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Empty pipeline: the next two outputs carry nothing.
    task automatic flush_model();
        exp_t e;
        e.vld = 1'b0;
        e.ev  = 0;
        e.od  = 0;
        expq.delete();
        expq.push_back(e);
        expq.push_back(e);
    endtask

    // Drive one cycle of input, advance one edge, compare with the op from three drives ago.
    task automatic step(input bit v, input int av, input int bv, input int wv, input string tag);
        exp_t e;
        int   am;
        int   pm;
        in_valid = v;
        a = av[COEFF_W-1:0];
        b = bv[COEFF_W-1:0];
        w = wv[COEFF_W-1:0];
        am = av % QM;
        pm = (bv * wv) % QM;
        e.vld = v;
        e.ev  = (am + pm) % QM;
        e.od  = (am - pm + QM) % QM;
        expq.push_back(e);
        @(posedge clk);
        #1;
        e = expq.pop_front();
        check({tag, ".vld"}, 32'(out_valid), 32'(e.vld));
        if (e.vld) begin
            check({tag, ".even"}, 32'(even), e.ev);
            check({tag, ".odd"},  32'(odd),  e.od);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        w = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.vld",  32'(out_valid), 0);
        check("rst.even", 32'(even), 0);
        check("rst.odd",  32'(odd), 0);
        rst_n = 1'b1;
        flush_model();

        // Single op: out_valid low after edges 1 and 2, high after edge 3.
        step(1, 2, 3, 1, "lat");
        step(0, 0, 0, 0, "idle");
        step(0, 0, 0, 0, "idle");
        step(0, 0, 0, 0, "idle");

        // Directed corners back-to-back, then again with a one-cycle gap.
        step(1, 3328, 1, 1, "addwrap");
        step(1, 100, 10, 100, "subwrap");
        step(1, 3328, 3328, 3328, "bw1");
        step(1, 0, 4095, 4095, "bwmax");
        step(1, 2, 3, 1, "b2b0");
        step(1, 3328, 1, 1, "b2b1");
        step(0, 0, 0, 0, "gap");
        step(1, 100, 10, 100, "b2b2");
        step(1, 3328, 3328, 3328, "b2b3");
        step(1, 4095, 0, 0, "anorm");
        step(1, 3329, 4095, 1, "aq");
        repeat (3) step(0, 0, 0, 0, "drain");

        // Reset asserted between edges with two ops in flight.
        step(1, 2, 3, 1, "pre0");
        step(1, 100, 10, 100, "pre1");
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst.vld",  32'(out_valid), 0);
        check("midrst.even", 32'(even), 0);
        check("midrst.odd",  32'(odd), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        flush_model();
        repeat (4) step(0, 0, 0, 0, "post");
        check("post.even", 32'(even), 0);
        check("post.odd",  32'(odd), 0);
        step(1, 2, 3, 1, "new");
        repeat (3) step(0, 0, 0, 0, "drain");

        // Random traffic with random gaps.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4095),
                 $urandom_range(0, 4095), $urandom_range(0, 4095), "rnd");
        end
        repeat (3) step(0, 0, 0, 0, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
